// File: rtl/gray2bin_arb.sv
// rtl/gray2bin_arb.sv - round-robin arbiter sharing one gray-to-binary converter
// among NREQ requesters, with a single registered output stage and result counter.

module gray2bin_conv #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] i_gray,
    output logic [SIZE-1:0] o_bin
);

    // Each binary bit is the XOR of all gray bits at or above it.
    function automatic logic [SIZE-1:0] f_g2b(input logic [SIZE-1:0] g);
        logic [SIZE-1:0] b;
        b[SIZE-1] = g[SIZE-1];
        for (int i = SIZE - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    assign o_bin = f_g2b(i_gray);

endmodule

module gray2bin_arb #(
    parameter int SIZE  = 8,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*SIZE-1:0] req_gray,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE-1:0]      out_bin,
    output logic [ID_W-1:0]      out_id,
    output logic [CNT_W-1:0]     conv_count
);

    logic [ID_W-1:0]  r_ptr;
    logic             r_out_valid;
    logic [SIZE-1:0]  r_out_bin;
    logic [ID_W-1:0]  r_out_id;
    logic [CNT_W-1:0] r_conv_count;

    logic             w_can_accept;
    logic             w_any;
    logic             w_accept;
    logic [ID_W-1:0]  w_grant;
    logic [ID_W-1:0]  w_next_ptr;
    logic [NREQ-1:0]  w_ready;
    logic [SIZE-1:0]  w_gray_sel;
    logic [SIZE-1:0]  w_bin;

    assign w_can_accept = ~r_out_valid | out_ready;
    assign w_accept     = w_can_accept & w_any;

    // Scan from the farthest offset back to the pointer so the nearest
    // requesting index (in wrap-around order) is the last one written.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req_valid[(int'(r_ptr) + off) % NREQ]) begin
                w_any   = 1'b1;
                w_grant = ID_W'((int'(r_ptr) + off) % NREQ);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_any) begin
            w_ready[w_grant] = w_can_accept;
        end
    end

    assign req_ready = w_ready;

    always_comb begin
        w_gray_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (ID_W'(k) == w_grant) begin
                w_gray_sel = req_gray[k*SIZE +: SIZE];
            end
        end
    end

    assign w_next_ptr = (int'(w_grant) == NREQ - 1) ? '0 : w_grant + ID_W'(1);

    gray2bin_conv #(
        .SIZE (SIZE)
    ) u_conv (
        .i_gray (w_gray_sel),
        .o_bin  (w_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_out_valid  <= 1'b0;
            r_out_bin    <= '0;
            r_out_id     <= '0;
            r_conv_count <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_conv_count <= r_conv_count + CNT_W'(1);
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_bin   <= w_bin;
                r_out_id    <= w_grant;
                r_ptr       <= w_next_ptr;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_bin    = r_out_bin;
    assign out_id     = r_out_id;
    assign conv_count = r_conv_count;

endmodule
